// File: rtl/adder_30_pkg.sv
// adder_30_pkg
// Shared constants and types for the adder_30 slice.
//   ADDER_30_WIDTH     operand width (3)
//   ADDER_30_SUM_W     sum width, operand width plus carry-out (4)
//   adder_30_sum_t     registered sum type
//   adder_30_operand_t packed {a, b, cin}, laid out a-high / cin-low so it
//                      matches the flat pi[6:0] bit order of the slice
package adder_30_pkg;

    localparam int ADDER_30_WIDTH = 3;
    localparam int ADDER_30_SUM_W = ADDER_30_WIDTH + 1;

    typedef logic [ADDER_30_SUM_W-1:0] adder_30_sum_t;

    typedef struct packed {
        logic [ADDER_30_WIDTH-1:0] a;
        logic [ADDER_30_WIDTH-1:0] b;
        logic                      cin;
    } adder_30_operand_t;

endpackage

// File: rtl/adder_30_if.sv
// adder_30_if
// Operand/result bundle of the adder_30 slice.
//   in_valid  operands valid this cycle          (master -> slave)
//   a, b      WIDTH-bit operands                 (master -> slave)
//   cin       carry-in                           (master -> slave)
//   out_valid sum register updated last cycle    (slave -> master)
//   sum       WIDTH+1-bit registered result      (slave -> master)
interface adder_30_if
    import adder_30_pkg::*;
#(
    parameter int WIDTH = ADDER_30_WIDTH
);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH:0]   sum;

    modport master (
        output in_valid, a, b, cin,
        input  out_valid, sum
    );

    modport slave (
        input  in_valid, a, b, cin,
        output out_valid, sum
    );

endinterface

// File: rtl/adder_30_fa.sv
// adder_30_fa / adder_30_fa_approx
// Single-bit adder cells for the adder_30 ripple chain.
//   i_a, i_b  operand bits
//   i_c       carry in
//   o_s       sum bit
//   o_c       carry out
// adder_30_fa is the exact full adder. adder_30_fa_approx is the cheaper
// LSB cell used only when ADDER_30_APPROX_EN is defined: the sum is an OR
// of the three inputs and the carry ignores the incoming carry.
module adder_30_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

module adder_30_fa_approx (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a | i_b | i_c;
    assign o_c = i_a & i_b;

endmodule

// File: rtl/adder_30_core.sv
// adder_30_core
// Registered WIDTH + WIDTH + carry-in adder slice, one-cycle latency.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, released on the next clk edge
//   bus    adder_30_if slave: in_valid, a, b, cin in; out_valid, sum out
// Build option: define ADDER_30_APPROX_EN to replace the bit-0 cell with
// the approximate cell; all timing, reset and valid behaviour is unchanged.
module adder_30_core
    import adder_30_pkg::*;
#(
    parameter int WIDTH = ADDER_30_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    adder_30_if.slave   bus
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH:0]   w_result;

    logic [WIDTH:0]   r_sum;
    logic             r_valid;

    assign w_c[0] = bus.cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        if (gi == 0) begin : g_lsb
`ifdef ADDER_30_APPROX_EN
            adder_30_fa_approx u_fa (
                .i_a (bus.a[gi]),
                .i_b (bus.b[gi]),
                .i_c (w_c[gi]),
                .o_s (w_s[gi]),
                .o_c (w_c[gi+1])
            );
`else
            adder_30_fa u_fa (
                .i_a (bus.a[gi]),
                .i_b (bus.b[gi]),
                .i_c (w_c[gi]),
                .o_s (w_s[gi]),
                .o_c (w_c[gi+1])
            );
`endif
        end else begin : g_upper
            adder_30_fa u_fa (
                .i_a (bus.a[gi]),
                .i_b (bus.b[gi]),
                .i_c (w_c[gi]),
                .o_s (w_s[gi]),
                .o_c (w_c[gi+1])
            );
        end
    end

    assign w_result = {w_c[WIDTH], w_s};

    // Sum only loads on valid cycles, so operands (even X) seen while
    // in_valid=0 never reach the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum <= w_result;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.sum       = r_sum;

endmodule

// File: tb/tb_adder_30_core.sv
module tb_adder_30_core;
    import adder_30_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    bit   cmp_en;

    // Reference state: what sum/out_valid must be after the latest edge.
    int   m_sum;
    bit   m_valid;

    adder_30_if #(.WIDTH(ADDER_30_WIDTH)) bus ();

    adder_30_core #(.WIDTH(ADDER_30_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Arithmetic reference for one operand set.
    function automatic int ref_sum(int a, int b, int c);
`ifdef ADDER_30_APPROX_EN
        int s0;
        int c1;
        s0 = (a | b | c) & 1;
        c1 = a & b & 1;
        return (((a >> 1) + (b >> 1) + c1) * 2) + s0;
`else
        return a + b + c;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sum   <= 0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= bus.in_valid;
            if (bus.in_valid)
                m_sum <= ref_sum(int'(bus.a), int'(bus.b), int'(bus.cin));
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_out_valid", int'(bus.out_valid), int'(m_valid));
            check("cmp_sum", int'(bus.sum), m_sum);
        end
    end

    task automatic step(input int flat, input bit v);
        adder_30_operand_t op;
        op = adder_30_operand_t'(flat[6:0]);
        bus.a        = op.a;
        bus.b        = op.b;
        bus.cin      = op.cin;
        bus.in_valid = v;
        @(posedge clk);
        #1;
    endtask

    int lit_exp;

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        cmp_en       = 1'b1;
        rst_n        = 1'b0;
        bus.a        = 3'b111;
        bus.b        = 3'b111;
        bus.cin      = 1'b1;
        bus.in_valid = 1'b1;

        // Model pinning with hand-computed values.
`ifdef ADDER_30_APPROX_EN
        check("pin_0010010", ref_sum(1, 1, 0), 3);
        check("pin_0000001", ref_sum(0, 0, 1), 1);
        check("pin_1111111", ref_sum(7, 7, 1), 15);
`else
        check("pin_0000001", ref_sum(0, 0, 1), 1);
        check("pin_1010101", ref_sum(5, 2, 1), 8);
        check("pin_0111110", ref_sum(3, 7, 0), 10);
        check("pin_1111111", ref_sum(7, 7, 1), 15);
`endif

        // Reset held with all-ones operands and in_valid=1.
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold_sum", int'(bus.sum), 0);
        check("reset_hold_valid", int'(bus.out_valid), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_sum", int'(bus.sum), 15);
        check("reset_release_valid", int'(bus.out_valid), 1);

        // Exhaustive back-to-back sweep with literal spot checks.
        for (int i = 0; i < 128; i++) begin
            step(i, 1'b1);
            lit_exp = -1;
`ifdef ADDER_30_APPROX_EN
            case (i)
                7'b0010010: lit_exp = 3;
                7'b0000001: lit_exp = 1;
                7'b1111111: lit_exp = 15;
                default:    lit_exp = -1;
            endcase
`else
            case (i)
                7'b0000001: lit_exp = 1;
                7'b0010010: lit_exp = 2;
                7'b1010101: lit_exp = 8;
                7'b0111110: lit_exp = 10;
                7'b1111111: lit_exp = 15;
                default:    lit_exp = -1;
            endcase
`endif
            if (lit_exp >= 0)
                check($sformatf("sweep_lit_%0d", i), int'(bus.sum), lit_exp);
        end

        // Hold: load 0110100 then idle with random operands.
        step(7'b0110100, 1'b1);
        check("hold_load_sum", int'(bus.sum), 5);
        for (int k = 0; k < 3; k++) begin
            step(int'($urandom_range(0, 127)), 1'b0);
            check("hold_sum", int'(bus.sum), 5);
            check("hold_valid", int'(bus.out_valid), 0);
        end

        // Random stream with a mid-stream asynchronous reset.
        for (int k = 0; k < 300; k++) begin
            if (k == 150) begin
                step(7'b1111111, 1'b1);
                #2;
                rst_n = 1'b0;
                #1;
                check("async_rst_sum", int'(bus.sum), 0);
                check("async_rst_valid", int'(bus.out_valid), 0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                step(int'($urandom_range(0, 127)), 1'b0);
                check("post_rst_sum", int'(bus.sum), 0);
                check("post_rst_valid", int'(bus.out_valid), 0);
            end else begin
                step(int'($urandom_range(0, 127)), ($urandom_range(0, 3) != 0));
            end
        end

        step(0, 1'b0);
        @(negedge clk);
        cmp_en = 1'b0;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
